cond_exec_ctrl: RTL and testbench

//  Execute-stage predication controller. Holds architectural NZCV flags and evaluates the 4-bit

---
 rtl/cond_exec_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cond_exec_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_ctrl.sv
// Execute-stage predication controller: NZCV flag register, condition evaluation,
// write/branch gating and post-branch squash window. Optional stats: COND_STATS_EN.
//
// state  | meaning
// RUN    | instructions may execute when valid and not stalled/flushed
// SQUASH | post-branch window; nothing executes, count_q cycles remain

module cond_exec_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_e,
    input  logic       stall_e,
    input  logic       flush_e,
    input  logic [3:0] cond_e,
    input  logic [1:0] flag_write_e,
    input  logic [3:0] alu_flags,
    input  logic       reg_write_e,
    input  logic       mem_write_e,
    input  logic       pc_src_e,
    output logic       reg_write_g,
    output logic       mem_write_g,
    output logic       pc_src_g,
    output logic [3:0] flags,
    output logic       cond_ex,
    output logic       squash_f,
    output logic       cond_err
`ifdef COND_STATS_EN
    ,
    output logic [15:0] exec_cnt,
    output logic [15:0] skip_cnt
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         flags_q, flags_d;
    logic               cond_err_q, cond_err_d;
    logic               squash_q, squash_d;
    logic               cond_pass;
    logic               live;
    logic               flag_n, flag_z, flag_c, flag_v;
    logic               ge, gt, hi;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    assign ge = (flag_n == flag_v);
    assign gt = !flag_z && ge;
    assign hi = flag_c && !flag_z;

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = hi;
            4'h9:    cond_pass = !hi;
            4'hA:    cond_pass = ge;
            4'hB:    cond_pass = !ge;
            4'hC:    cond_pass = gt;
            4'hD:    cond_pass = !gt;
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Reset is folded in so the gated outputs stay quiet while reset is held.
    assign live = !reset && valid_e && !stall_e && !flush_e && (state_q == ST_RUN);

    assign reg_write_g = reg_write_e && cond_pass && live;
    assign mem_write_g = mem_write_e && cond_pass && live;
    assign pc_src_g    = pc_src_e    && cond_pass && live;
    assign cond_ex     = cond_pass;
    assign flags       = flags_q;
    assign squash_f    = squash_q;
    assign cond_err    = cond_err_q;

    always_comb begin
        flags_d    = flags_q;
        cond_err_d = cond_err_q;
        state_d    = state_q;
        count_d    = count_q;

        if (live && cond_pass) begin
            if (flag_write_e[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_write_e[0]) flags_d[1:0] = alu_flags[1:0];
        end

        if (live && (cond_e == 4'hF)) cond_err_d = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (pc_src_g) begin
                    state_d = ST_SQUASH;
                    count_d = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_SQUASH: begin
                if (!stall_e) begin
                    if (count_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                count_d = '0;
            end
        endcase

        squash_d = (state_d == ST_SQUASH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            flags_q    <= 4'b0000;
            cond_err_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            flags_q    <= flags_d;
            cond_err_q <= cond_err_d;
            squash_q   <= squash_d;
        end
    end

`ifdef COND_STATS_EN
    logic [15:0] exec_cnt_q, exec_cnt_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (live && cond_pass && (exec_cnt_q != 16'hFFFF))
            exec_cnt_d = exec_cnt_q + 16'd1;
        if (live && !cond_pass && (skip_cnt_q != 16'hFFFF))
            skip_cnt_d = skip_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed self-checking bench for cond_exec_ctrl (default FLUSH_CYCLES=2).

module tb_cond_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_e, stall_e, flush_e;
    logic [3:0] cond_e;
    logic [1:0] flag_write_e;
    logic [3:0] alu_flags;
    logic       reg_write_e, mem_write_e, pc_src_e;
    logic       reg_write_g, mem_write_g, pc_src_g;
    logic [3:0] flags;
    logic       cond_ex, squash_f, cond_err;
`ifdef COND_STATS_EN
    logic [15:0] exec_cnt, skip_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cond_exec_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .valid_e      (valid_e),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .cond_e       (cond_e),
        .flag_write_e (flag_write_e),
        .alu_flags    (alu_flags),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .pc_src_e     (pc_src_e),
        .reg_write_g  (reg_write_g),
        .mem_write_g  (mem_write_g),
        .pc_src_g     (pc_src_g),
        .flags        (flags),
        .cond_ex      (cond_ex),
        .squash_f     (squash_f),
        .cond_err     (cond_err)
`ifdef COND_STATS_EN
        ,
        .exec_cnt     (exec_cnt),
        .skip_cnt     (skip_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        valid_e = 0; stall_e = 0; flush_e = 0; cond_e = 4'hE;
        flag_write_e = 2'b00; alu_flags = 4'h0;
        reg_write_e = 0; mem_write_e = 0; pc_src_e = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cond_sweep(input string tag, input logic [15:0] exp_vec);
        logic [15:0] got_vec;
        got_vec = '0;
        valid_e = 0;
        for (int i = 0; i < 16; i++) begin
            cond_e = 4'(i);
            #1;
            got_vec[i] = cond_ex;
        end
        chk(tag, got_vec, exp_vec);
        cond_e = 4'hE;
    endtask

    initial begin
        int hi_cnt;
        idle();
        reset = 1;
        step();
        step();
        // Reset state, with a live-looking instruction presented during reset
        valid_e = 1; reg_write_e = 1; pc_src_e = 1;
        #1;
        chk("rst_flags", 16'(flags), 16'h0);
        chk("rst_squash", 16'(squash_f), 16'h0);
        chk("rst_cond_err", 16'(cond_err), 16'h0);
        chk("rst_rw_g", 16'(reg_write_g), 16'h0);
        chk("rst_pc_g", 16'(pc_src_g), 16'h0);
        step();
        chk("rst_squash_held", 16'(squash_f), 16'h0);
        idle();
        reset = 0;

        // 1: AL with flag write
        valid_e = 1; cond_e = 4'hE; reg_write_e = 1; flag_write_e = 2'b11; alu_flags = 4'b0100;
        #1;
        chk("t1_rw_g", 16'(reg_write_g), 16'h1);
        chk("t1_flags_before", 16'(flags), 16'h0);
        step();
        chk("t1_flags_after", 16'(flags), 16'h4);

        // 2: EQ passes, NE fails and writes nothing
        idle();
        valid_e = 1; cond_e = 4'h0;
        #1;
        chk("t2_eq", 16'(cond_ex), 16'h1);
        cond_e = 4'h1; mem_write_e = 1; flag_write_e = 2'b11; alu_flags = 4'b1111;
        #1;
        chk("t2_ne", 16'(cond_ex), 16'h0);
        chk("t2_mw_g", 16'(mem_write_g), 16'h0);
        step();
        chk("t2_flags_kept", 16'(flags), 16'h4);
        idle();
        cond_sweep("sweep_0100", 16'h66A9);

        // Stall and flush in RUN block commit
        valid_e = 1; reg_write_e = 1; flag_write_e = 2'b11; alu_flags = 4'b1111; stall_e = 1;
        #1;
        chk("stall_rw_g", 16'(reg_write_g), 16'h0);
        step();
        chk("stall_flags", 16'(flags), 16'h4);
        stall_e = 0; flush_e = 1;
        #1;
        chk("flush_rw_g", 16'(reg_write_g), 16'h0);
        step();
        chk("flush_flags", 16'(flags), 16'h4);
        idle();

        // 3: taken branch then 2-cycle squash window
        valid_e = 1; pc_src_e = 1;
        #1;
        chk("t3_pc_g", 16'(pc_src_g), 16'h1);
        step();
        pc_src_e = 0; reg_write_e = 1; flag_write_e = 2'b11; alu_flags = 4'b1111;
        #1;
        chk("t3_sq_c1", 16'(squash_f), 16'h1);
        chk("t3_rw_g_c1", 16'(reg_write_g), 16'h0);
        step();
        chk("t3_sq_c2", 16'(squash_f), 16'h1);
        chk("t3_rw_g_c2", 16'(reg_write_g), 16'h0);
        step();
        chk("t3_sq_end", 16'(squash_f), 16'h0);
        chk("t3_rw_g_run", 16'(reg_write_g), 16'h1);
        chk("t3_flags_kept", 16'(flags), 16'h4);
        idle();

        // 4: stall held 3 cycles inside the window stretches it to 5
        valid_e = 1; pc_src_e = 1;
        step();
        idle();
        stall_e = 1;
        hi_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (squash_f) hi_cnt++;
            if (i == 3) stall_e = 0;
            step();
        end
        chk("t4_sq_cycles", 16'(hi_cnt), 16'd5);
        idle();

        // 5: undefined condition
        valid_e = 1; cond_e = 4'hF; reg_write_e = 1; flush_e = 1;
        #1;
        chk("t5_cond_ex_flush", 16'(cond_ex), 16'h0);
        step();
        chk("t5_err_flush", 16'(cond_err), 16'h0);
        flush_e = 0;
        #1;
        chk("t5_rw_g", 16'(reg_write_g), 16'h0);
        step();
        chk("t5_err_set", 16'(cond_err), 16'h1);
        idle();
        step();
        step();
        chk("t5_err_sticky", 16'(cond_err), 16'h1);

        // 6: set N=1,V=0, then LT updates only C,V
        valid_e = 1; flag_write_e = 2'b11; alu_flags = 4'b1000;
        step();
        chk("t6_flags_1000", 16'(flags), 16'h8);
        cond_e = 4'hB; flag_write_e = 2'b01; alu_flags = 4'b0011;
        #1;
        chk("t6_lt", 16'(cond_ex), 16'h1);
        step();
        chk("t6_flags_1011", 16'(flags), 16'hB);
        idle();
        cond_sweep("sweep_1011", 16'h5556);

        // Taken branch that also sets flags, then reset mid-window
        valid_e = 1; pc_src_e = 1; flag_write_e = 2'b11; alu_flags = 4'b0110;
        step();
        idle();
        #1;
        chk("br_flags", 16'(flags), 16'h6);
        chk("br_sq", 16'(squash_f), 16'h1);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("rst_mid_sq", 16'(squash_f), 16'h0);
        chk("rst_mid_flags", 16'(flags), 16'h0);
        chk("rst_mid_err", 16'(cond_err), 16'h0);
        valid_e = 1; reg_write_e = 1;
        #1;
        chk("rst_mid_run", 16'(reg_write_g), 16'h1);
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
